// File: rtl/rr_arbiter_4to1.sv
// Four-requester round-robin arbiter with a registered output stage.
// The winning requester's word and 2-bit source code are captured on a valid/ready handshake.
module rr_arbiter_4to1 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [DATA_WIDTH-1:0] C,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic [3:0]            in_valid,
  output logic [3:0]            in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            out_src,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  xfer_cnt
);

  logic [1:0]            ptr_q;
  logic [1:0]            winner;
  logic [1:0]            idx;
  logic                  found;
  logic                  load;
  logic [DATA_WIDTH-1:0] sel_data;

  // Scan ptr, ptr+1, ptr+2, ptr+3; the 2-bit index wraps naturally.
  always_comb begin
    winner = 2'd0;
    found  = 1'b0;
    idx    = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && in_valid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    unique case (winner)
      2'd0: sel_data = A;
      2'd1: sel_data = B;
      2'd2: sel_data = C;
      2'd3: sel_data = D;
      default: sel_data = '0;
    endcase
  end

  // Gating with rst_n keeps every handshake from completing during reset.
  assign load = rst_n && (!out_valid || out_ready) && found;

  always_comb begin
    in_ready = 4'b0000;
    if (load) begin
      in_ready[winner] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 2'd0;
      ptr_q     <= 2'd0;
      xfer_cnt  <= '0;
    end else begin
      if (load) begin
        out_data  <= sel_data;
        out_src   <= winner;
        out_valid <= 1'b1;
        ptr_q     <= winner + 2'd1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (out_valid && out_ready) begin
        xfer_cnt <= xfer_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rr_arbiter_4to1.sv
// Directed bench for rr_arbiter_4to1; a CNT_WIDTH=4 copy shares the stimulus to observe wrap.
module tb_rr_arbiter_4to1;

  logic        clk;
  logic        rst_n;
  logic [31:0] a_w, b_w, c_w, d_w;
  logic [3:0]  in_valid;
  logic        out_ready;

  logic [3:0]  in_ready, in_ready4;
  logic [31:0] out_data, out_data4;
  logic [1:0]  out_src, out_src4;
  logic        out_valid, out_valid4;
  logic [15:0] xfer_cnt;
  logic [3:0]  xfer_cnt4;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] words [4];

  rr_arbiter_4to1 #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .A(a_w), .B(b_w), .C(c_w), .D(d_w),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_src(out_src),
    .out_valid(out_valid), .out_ready(out_ready), .xfer_cnt(xfer_cnt)
  );

  rr_arbiter_4to1 #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .A(a_w), .B(b_w), .C(c_w), .D(d_w),
    .in_valid(in_valid), .in_ready(in_ready4), .out_data(out_data4), .out_src(out_src4),
    .out_valid(out_valid4), .out_ready(out_ready), .xfer_cnt(xfer_cnt4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One load: check the grant before the edge, then the registered word after it.
  task automatic step(input logic [3:0] exp_ready, input logic [1:0] exp_src,
                      input logic [31:0] exp_data, input int exp_cnt);
    #1;
    check_eq("in_ready", 64'(in_ready), 64'(exp_ready));
    tick();
    check_eq("out_src", 64'(out_src), 64'(exp_src));
    check_eq("out_data", 64'(out_data), 64'(exp_data));
    check_eq("out_valid", 64'(out_valid), 64'd1);
    check_eq("xfer_cnt", 64'(xfer_cnt), 64'(exp_cnt));
    check_eq("xfer_cnt4", 64'(xfer_cnt4), 64'(exp_cnt % 16));
  endtask

  initial begin
    a_w = 32'h0000_00A0;
    b_w = 32'h0000_00B0;
    c_w = 32'h0000_00C0;
    d_w = 32'h0000_00D0;
    words[0] = 32'h0000_00A0;
    words[1] = 32'h0000_00B0;
    words[2] = 32'h0000_00C0;
    words[3] = 32'h0000_00D0;
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;

    // In reset: all outputs cleared and no grant despite requests.
    #3;
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_data", 64'(out_data), 64'd0);
    check_eq("rst_out_src", 64'(out_src), 64'd0);
    check_eq("rst_xfer_cnt", 64'(xfer_cnt), 64'd0);
    tick();
    tick();
    rst_n    = 1'b1;
    in_valid = 4'b0000;

    // Idle cycles: nothing granted, nothing counted.
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("idle_in_ready", 64'(in_ready), 64'd0);
      tick();
      check_eq("idle_out_valid", 64'(out_valid), 64'd0);
      check_eq("idle_xfer_cnt", 64'(xfer_cnt), 64'd0);
    end

    // All requesting: grants rotate 0,1,2,3,0,... at one word per cycle.
    in_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      step(4'b0001 << (k % 4), 2'(k % 4), words[k % 4], k);
    end
    in_valid = 4'b0000;
    #1;
    check_eq("drain_in_ready", 64'(in_ready), 64'd0);
    tick();
    check_eq("drain_xfer_cnt", 64'(xfer_cnt), 64'd8);
    check_eq("drain_out_valid", 64'(out_valid), 64'd0);

    // Single requester C, then scan from 3 wraps to 0, then 1.
    in_valid = 4'b0100;
    step(4'b0100, 2'd2, 32'h0000_00C0, 8);
    in_valid = 4'b0011;
    step(4'b0001, 2'd0, 32'h0000_00A0, 9);
    step(4'b0010, 2'd1, 32'h0000_00B0, 10);

    // Output stall: word B held, no grant, pointer frozen at 2.
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("stall_in_ready", 64'(in_ready), 64'd0);
      tick();
      check_eq("stall_out_src", 64'(out_src), 64'd1);
      check_eq("stall_out_data", 64'(out_data), 64'h0000_00B0);
      check_eq("stall_out_valid", 64'(out_valid), 64'd1);
      check_eq("stall_xfer_cnt", 64'(xfer_cnt), 64'd10);
    end
    out_ready = 1'b1;
    step(4'b0100, 2'd2, 32'h0000_00C0, 11);

    // Continue to 17 transfers; the 4-bit counter wraps to 1.
    step(4'b1000, 2'd3, 32'h0000_00D0, 12);
    step(4'b0001, 2'd0, 32'h0000_00A0, 13);
    step(4'b0010, 2'd1, 32'h0000_00B0, 14);
    step(4'b0100, 2'd2, 32'h0000_00C0, 15);
    step(4'b1000, 2'd3, 32'h0000_00D0, 16);
    step(4'b0001, 2'd0, 32'h0000_00A0, 17);
    check_eq("wrap_xfer_cnt4", 64'(xfer_cnt4), 64'd1);

    // Asynchronous reset mid-cycle while stalled with a held word.
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", 64'(out_valid), 64'd0);
    check_eq("arst_in_ready", 64'(in_ready), 64'd0);
    check_eq("arst_xfer_cnt", 64'(xfer_cnt), 64'd0);
    check_eq("arst_out_data", 64'(out_data), 64'd0);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step(4'b0001, 2'd0, 32'h0000_00A0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_4to1.md
Name: rr_arbiter_4to1

Overview:
- Four-requester round-robin arbiter with a registered output stage.
- Sits directly upstream of the team's 4-to-1 data mux: it produces the 2-bit select code and steers the chosen requester's word onto one output channel.
- A valid/ready handshake is used on every input and on the output.
- Provides fair access for four producers sharing one downstream consumer.

Parameters:
- DATA_WIDTH, 32, width of each data word.
- CNT_WIDTH, 16, width of the transfer counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- A  input  DATA_WIDTH  requester 0 data.
- B  input  DATA_WIDTH  requester 1 data.
- C  input  DATA_WIDTH  requester 2 data.
- D  input  DATA_WIDTH  requester 3 data.
- in_valid  input  4  bit i = requester i has a word.
- in_ready  output  4  one-hot; bit i = requester i's word is accepted this cycle.
- out_data  output  DATA_WIDTH  registered granted word.
- out_src  output  2  registered select code of the granted requester (0=A, 1=B, 2=C, 3=D).
- out_valid  output  1  out_data/out_src hold a word.
- out_ready  input  1  consumer accepts the word.
- xfer_cnt  output  CNT_WIDTH  count of completed output transfers.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_data=0, out_src=0, xfer_cnt=0, pointer ptr=0.
  - in_ready forced to 4'b0000 while rst_n is low.
- load = (!out_valid || out_ready) && (in_valid != 0). This is the output register's accept condition.
- Winner selection:
  - Scan starts at index ptr and goes ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - The first index with in_valid set wins.
  - Selection is purely combinational in the same cycle.
- in_ready:
  - When load, in_ready = one-hot(winner); otherwise 0.
  - Never more than one bit set.
  - A requester's handshake completes when in_valid[i] && in_ready[i].
- On a clock edge with load:
  - out_data <= selected word; out_src <= winner; out_valid <= 1.
  - ptr <= winner+1 mod 4 (3 wraps to 0).
- On a clock edge with out_valid && out_ready && !load: out_valid <= 0.
- Output stall: while out_valid && !out_ready, out_data, out_src and out_valid hold stable, ptr holds, in_ready=0.
- Simultaneous drain and refill: out_valid && out_ready && a requester present gives back-to-back transfers at 1 word/cycle, with no bubble.
- Latency: an input accepted at edge N appears on out_data after edge N (registered, 1 cycle).
- Fairness: with all four requesters continuously valid, grants rotate 0,1,2,3,0,... No requester waits more than 3 grants.
- Idle pointer: ptr changes only on a grant; an idle cycle does not advance it.
- xfer_cnt: increments by 1 on each edge with out_valid && out_ready; wraps from all-ones to 0.
- in_valid dropping without a handshake is legal; it is simply not considered.
- Reset mid-transfer discards any held word immediately. No handshake completes in a cycle where rst_n is low.

Test Plan:
- Reset, then in_valid=4'b0000 for 5 cycles -> in_ready=0, out_valid=0, xfer_cnt=0, ptr remains 0.
- A=32'h0000_00A0 … D=32'h0000_00D0, in_valid=4'b1111, out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3, one word per cycle, xfer_cnt=8.
- in_valid=4'b0100 only, out_ready=1 -> first grant in_ready=4'b0100, out_data=C, out_src=2. Then in_valid=4'b0011 -> winner 0 (scan 3,0), next grant 1.
- out_ready=0 after one word loaded, in_valid=4'b1111 for 4 cycles -> out_data/out_src constant, in_ready=0. Raise out_ready -> held word is accepted and a new word loads on the same edge.
- CNT_WIDTH=4, 17 continuous transfers -> xfer_cnt reads 1 after wrap.
- Assert rst_n=0 asynchronously mid-cycle while out_valid=1 and out_ready=0 -> out_valid=0, in_ready=0 immediately. After release, the first grant with in_valid=4'b1111 goes to requester 0.
